div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the EX stage, serving DIV/DIVU. Performs radix-2 restoring division, one quotient bit per cycle. It raises a stall request toward CTRL (the `stallreq_for_ex` input) for as long as a started division has not produced its result. The result is written back to HI/LO through the EX/MEM path.

---
 rtl/div_unit_pkg.sv | 20 ++
 rtl/div_unit.sv | 103 ++++++++++
 tb/tb_div_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state encodings and handshake constants for the EX-stage divider
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic STOP                 = 1'b1;
  localparam logic NO_STOP              = 1'b0;

endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU with stall request to CTRL
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e       r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_rem;
  logic             r_neg_q, r_neg_r;
  logic [WIDTH:0]   w_trial, w_diff;
  logic [WIDTH-1:0] w_abs1, w_abs2;
  logic             w_ge, w_accept, w_done, w_sign1, w_sign2;

  assign w_accept = (start_i == DIV_START) && !annul_i;
  assign w_sign1  = signed_div_i && opdata1_i[WIDTH-1];
  assign w_sign2  = signed_div_i && opdata2_i[WIDTH-1];
  assign w_abs1   = w_sign1 ? -opdata1_i : opdata1_i;
  assign w_abs2   = w_sign2 ? -opdata2_i : opdata2_i;
  // trial is always below twice the divisor, so the borrow bit alone decides R >= divisor
  assign w_trial  = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff   = w_trial - {1'b0, r_dvs};
  assign w_ge     = !w_diff[WIDTH];
  assign w_done   = r_cnt == CW'(WIDTH);
  assign stallreq_o = (rst && start_i == DIV_START && r_state != DIV_END) ? STOP : NO_STOP;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= DIV_FREE;
    else      r_state <= w_next;
  end

  // next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      DIV_FREE:    w_next = !w_accept ? DIV_FREE : (opdata2_i == '0 ? DIV_BY_ZERO : DIV_ON);
      DIV_BY_ZERO: w_next = DIV_END;
      DIV_ON:      w_next = annul_i ? DIV_FREE : (w_done ? DIV_END : DIV_ON);
      DIV_END:     w_next = (start_i == DIV_STOP) ? DIV_FREE : DIV_END;
      default:     w_next = DIV_FREE;
    endcase
  end

  // operand capture, one quotient bit per cycle, sign fix-up and result latch
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (r_state)
        DIV_FREE: if (w_accept && opdata2_i != '0) begin
          r_cnt   <= '0;
          r_dvd   <= w_abs1;
          r_dvs   <= w_abs2;
          r_rem   <= '0;
          r_neg_q <= w_sign1 ^ w_sign2;
          r_neg_r <= w_sign1;
        end
        DIV_BY_ZERO: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_READY;
        end
        DIV_ON: if (!annul_i) begin
          if (!w_done) begin
            r_rem <= w_ge ? w_diff[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
            r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
          end else begin
            result_o <= {r_neg_r ? -r_rem : r_rem, r_neg_q ? -r_dvd : r_dvd};
            ready_o  <= DIV_RESULT_READY;
          end
        end
        DIV_END: if (start_i == DIV_STOP) begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit against an arithmetic reference model
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;

  typedef struct {
    logic [63:0] res;
    int          c0;
    int          lat;
  } item_t;

  item_t sb_q[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  ready_prev = 1'b0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // truncating integer division in 64-bit arithmetic; divide-by-zero yields 0
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    sa = s ? {{32{a[31]}}, a} : {32'd0, a};
    sb = s ? {{32{b[31]}}, b} : {32'd0, b};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // monitor: every rising ready pops one expected result and its latency
  always @(negedge clk) begin
    if (rst && ready_o && !ready_prev) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got result %h with nothing outstanding", result_o);
      end else begin
        item_t it;
        it = sb_q.pop_front();
        check("result", result_o, it.res);
        check("latency", 64'(cyc - it.c0), 64'(it.lat));
      end
    end
    ready_prev = ready_o;
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    logic [63:0] e;
    bit          got;
    e = model(a, b, s);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    sb_q.push_back('{e, cyc, (b == 0) ? 2 : 34});
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1;
        break;
      end
      check("stall_busy", 64'(stallreq_o), 64'd1);
    end
    if (!got) begin
      check("ready_timeout", 64'(ready_o), 64'd1);
      void'(sb_q.pop_back());
      start_i = 1'b0;
      @(negedge clk);
      return;
    end
    check("stall_at_ready", 64'(stallreq_o), 64'd0);
    repeat (hold) begin
      @(negedge clk);
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, e);
    end
    start_i   = 1'b0;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    @(negedge clk);
    check("drop_ready", 64'(ready_o), 64'd0);
    check("drop_result", result_o, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          sel;
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(negedge clk);
    start_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    #1;
    check("reset_stall", 64'(stallreq_o), 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, 1);
    run_div(-32'sd7, 32'd2, 1'b1, 0);
    run_div(32'd7, -32'sd2, 1'b1, 2);
    run_div(32'd5, 32'd0, 1'b0, 1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 5);
    run_div(32'd3, 32'd9, 1'b1, 0);

    // annul mid-division: no result, stall released once start drops
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    #1;
    check("annul_stall", 64'(stallreq_o), 64'd0);
    check("annul_ready", 64'(ready_o), 64'd0);
    repeat (40) @(negedge clk);
    check("annul_no_ready", 64'(ready_o), 64'd0);
    run_div(32'd9, 32'd3, 1'b0, 1);

    // annul while idle blocks the accept
    @(negedge clk);
    opdata1_i = 32'd77; opdata2_i = 32'd0; start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(negedge clk);
    check("annul_free_ready", 64'(ready_o), 64'd0);
    start_i = 1'b0; annul_i = 1'b0;
    repeat (4) @(negedge clk);
    check("annul_free_idle", 64'(ready_o), 64'd0);

    // reset mid-division
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd123456; opdata2_i = 32'd77; start_i = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    check("rst_mid_stall_after", 64'(stallreq_o), 64'd0);
    run_div(32'd123456, 32'd77, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      s   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      a   = (sel == 7) ? 32'd0 : $urandom;
      b   = (sel == 0) ? 32'd0 :
            (sel < 3)  ? 32'($urandom_range(1, 20)) :
            (sel == 3) ? -32'($urandom_range(1, 20)) : $urandom;
      run_div(a, b, s, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
